// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a load handshake and a bit counter.
// Back-to-back frames are gap-free, and a one-cycle done pulse follows each completed frame.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0,
    localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rs,
    input  logic [WIDTH-1:0] PI,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             done,
    output logic [CW-1:0]    busy_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] shreg_r, shreg_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic             done_r, done_nx_s;
    logic             shift_s, last_s, head_s;

    // Move every bit one place toward the transmitted end and zero-fill the far end.
    function automatic logic [WIDTH-1:0] shift_to_head(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (MSB_FIRST) begin
            r = {v[WIDTH-2:0], 1'b0};
        end else begin
            r = {1'b0, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    assign shift_s    = (state_r == ST_SHIFT);
    assign last_s     = shift_s && (cnt_r == CNT_LAST);
    assign head_s     = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];

    // Outputs are pure decodes of state, counter and shift register, so nothing combinational reaches sout from load or PI.
    assign sout       = shift_s ? head_s : IDLE_LEVEL;
    assign sout_valid = shift_s;
    assign sout_last  = last_s;
    assign ready      = !shift_s || last_s;
    assign done       = done_r;
    assign busy_cnt   = cnt_r;

    // Next-state, shift-register and counter update.
    always_comb begin
        state_nx_s = state_r;
        shreg_nx_s = shreg_r;
        cnt_nx_s   = cnt_r;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_nx_s = ST_SHIFT;
                    shreg_nx_s = PI;
                    cnt_nx_s   = CNT_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    done_nx_s = 1'b1;
                    // A load on the final bit chains the next word with no idle gap.
                    if (load) begin
                        state_nx_s = ST_SHIFT;
                        shreg_nx_s = PI;
                        cnt_nx_s   = CNT_ZERO;
                    end else begin
                        state_nx_s = ST_IDLE;
                        shreg_nx_s = {WIDTH{1'b0}};
                        cnt_nx_s   = CNT_ZERO;
                    end
                end else begin
                    shreg_nx_s = shift_to_head(shreg_r);
                    cnt_nx_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                shreg_nx_s = {WIDTH{1'b0}};
                cnt_nx_s   = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous reset, which takes priority over load.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            shreg_r <= shreg_nx_s;
            cnt_r   <= cnt_nx_s;
            done_r  <= done_nx_s;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances run in lockstep on the same stimulus.
// Expected bits are queued when a word is loaded, and a negedge monitor pops and checks them.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rs;
    logic [7:0] pi;
    logic       load;

    logic       ready_m, sout_m, valid_m, last_m, done_m;
    logic [2:0] cnt_m;
    logic       ready_l, sout_l, valid_l, last_l, done_l;
    logic [2:0] cnt_l;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit exp_done = 1'b0;

    typedef struct packed {
        logic       sm;
        logic       sl;
        logic [2:0] cnt;
        logic       last;
    } exp_t;
    exp_t q[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rs(rs), .PI(pi), .load(load), .ready(ready_m), .sout(sout_m),
        .sout_valid(valid_m), .sout_last(last_m), .done(done_m), .busy_cnt(cnt_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rs(rs), .PI(pi), .load(load), .ready(ready_l), .sout(sout_l),
        .sout_valid(valid_l), .sout_last(last_l), .done(done_l), .busy_cnt(cnt_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Queue the expected bit stream of one word for both bit orders.
    task automatic push_frame(input logic [7:0] w);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.sm   = w[7-k];
            e.sl   = w[k];
            e.cnt  = 3'(k);
            e.last = (k == 7);
            q.push_back(e);
        end
    endtask

    task automatic load_word(input logic [7:0] w, input bit expect_accept);
        @(posedge clk);
        #1;
        pi   = w;
        load = 1'b1;
        if (expect_accept) push_frame(w);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Monitor: compares both instances against the scoreboard every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("done_m", {31'd0, done_m}, {31'd0, exp_done});
            chk("done_l", {31'd0, done_l}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (valid_m || valid_l) begin
                chk("valid_lockstep", {31'd0, valid_l}, {31'd0, valid_m});
                if (q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sout_m", {31'd0, sout_m}, {31'd0, e.sm});
                    chk("sout_l", {31'd0, sout_l}, {31'd0, e.sl});
                    chk("cnt_m", {29'd0, cnt_m}, {29'd0, e.cnt});
                    chk("cnt_l", {29'd0, cnt_l}, {29'd0, e.cnt});
                    chk("last_m", {31'd0, last_m}, {31'd0, e.last});
                    chk("last_l", {31'd0, last_l}, {31'd0, e.last});
                    chk("ready_m_busy", {31'd0, ready_m}, {31'd0, e.last});
                    chk("ready_l_busy", {31'd0, ready_l}, {31'd0, e.last});
                    exp_done = e.last;
                end
            end else begin
                chk("idle_sout", {30'd0, sout_m, sout_l}, 32'd0);
                chk("idle_ready", {30'd0, ready_m, ready_l}, 32'd3);
                chk("idle_last", {30'd0, last_m, last_l}, 32'd0);
            end
        end
    end

    initial begin
        rs   = 1'b1;
        pi   = 8'h00;
        load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rs = 1'b0;
        chk("rst_valid", {30'd0, valid_m, valid_l}, 32'd0);
        chk("rst_ready", {30'd0, ready_m, ready_l}, 32'd3);
        chk("rst_done", {30'd0, done_m, done_l}, 32'd0);
        chk("rst_cnt", {26'd0, cnt_m, cnt_l}, 32'd0);
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame 8'hBA: MSB order 1,0,1,1,1,0,1,0; LSB order 0,1,0,1,1,1,0,1.
        load_word(8'hBA, 1'b1);
        repeat (10) @(posedge clk);

        // Back-to-back 8'hF0 then 8'h0F, with the reload on the edge that ends the last bit.
        load_word(8'hF0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk("b2b_last", {30'd0, last_m, last_l}, 32'd3);
        chk("b2b_ready", {30'd0, ready_m, ready_l}, 32'd3);
        pi   = 8'h0F;
        load = 1'b1;
        push_frame(8'h0F);
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("b2b_nogap", {30'd0, valid_m, valid_l}, 32'd3);
        chk("b2b_done", {30'd0, done_m, done_l}, 32'd3);
        chk("b2b_cnt0", {26'd0, cnt_m, cnt_l}, 32'd0);
        repeat (10) @(posedge clk);

        // A load during bit 3 must be ignored.
        load_word(8'hBA, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ready", {30'd0, ready_m, ready_l}, 32'd0);
        pi   = 8'h55;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        pi   = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_back_idle", {30'd0, valid_m, valid_l}, 32'd0);

        // Reset on the edge that ends bit 4 aborts the frame without a done pulse.
        load_word(8'hBA, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rs = 1'b1;
        @(posedge clk);
        #1;
        rs = 1'b0;
        q.delete();
        chk("abort_valid", {30'd0, valid_m, valid_l}, 32'd0);
        chk("abort_sout", {30'd0, sout_m, sout_l}, 32'd0);
        chk("abort_ready", {30'd0, ready_m, ready_l}, 32'd3);
        chk("abort_cnt", {26'd0, cnt_m, cnt_l}, 32'd0);
        repeat (2) @(posedge clk);
        load_word(8'h81, 1'b1);
        repeat (10) @(posedge clk);
        #1;

        chk("queue_drained", q.size(), 32'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
